// File: rtl/mem_pkg.sv
// Shared types and default sizes for the segmented-memory access arbiter.
package mem_pkg;

  localparam int unsigned MEM_WIDTH      = 36;
  localparam int unsigned MEM_SEG0_DEPTH = 1024;
  localparam int unsigned MEM_SEG1_DEPTH = 102;
  localparam int unsigned MEM_SEG2_DEPTH = 100;

  typedef enum logic [1:0] {
    SEG_INSTR = 2'd0,
    SEG_D16   = 2'd1,
    SEG_D8    = 2'd2,
    SEG_BAD   = 2'd3
  } seg_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin: on a tie the port not granted last wins.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] win_c_o
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    win_c_o = 2'b00;
    unique case (req_i)
      2'b01:   win_c_o = 2'b01;
      2'b10:   win_c_o = 2'b10;
      2'b11:   win_c_o = last_grant_q ? 2'b01 : 2'b10;
      default: win_c_o = 2'b00;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (advance_i && (|win_c_o)) last_grant_d = win_c_o[1];
  end

  // Reset to port 1 so port 0 has first priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_grant_q <= 1'b1;
    else       last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Arbitrates CPU and host access to the segmented memory; segment 0 is
// otherwise handed to instruction fetch.
module mem_access_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned WIDTH      = MEM_WIDTH,
  parameter int unsigned SEG0_DEPTH = MEM_SEG0_DEPTH,
  parameter int unsigned SEG1_DEPTH = MEM_SEG1_DEPTH,
  parameter int unsigned SEG2_DEPTH = MEM_SEG2_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req,
  input  logic [1:0]         we,
  input  logic [2*WIDTH-1:0] addr,
  input  logic [2*WIDTH-1:0] wdata,
  output logic [1:0]         gnt,
  output logic [1:0]         rvalid,
  output logic [WIDTH-1:0]   rdata,
  output logic               err,
  input  logic [WIDTH-1:0]   fetch_addr,
  output logic [WIDTH-1:0]   fetch_instr,
  output logic               fetch_stall,
  output logic [3:0]         mem_we,
  output logic [3*WIDTH-1:0] mem_a,
  output logic [3*WIDTH-1:0] mem_wd,
  input  logic [3*WIDTH-1:0] mem_rd
);

  localparam int unsigned OFF_W = WIDTH - 2;

  arb_state_t       state_q;
  logic             port_q;
  logic             we_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;

  logic [1:0]       win;
  seg_t             seg;
  logic [OFF_W-1:0] off;
  logic             valid;
  logic [WIDTH-1:0] rd_sel;
  logic             busy;

  rr_arbiter2 u_rr (
    .clk       (clk),
    .reset     (reset),
    .req_i     (req),
    .advance_i (state_q == IDLE),
    .win_c_o   (win)
  );

  assign seg  = seg_t'(addr_q[WIDTH-1 -: 2]);
  assign off  = addr_q[OFF_W-1:0];
  assign busy = (state_q == BUSY);

  always_comb begin
    valid = 1'b0;
    unique case (seg)
      SEG_INSTR: valid = (off < OFF_W'(SEG0_DEPTH));
      SEG_D16:   valid = (off < OFF_W'(SEG1_DEPTH));
      SEG_D8:    valid = (off < OFF_W'(SEG2_DEPTH));
      default:   valid = 1'b0;
    endcase
  end

  always_comb begin
    rd_sel = '0;
    unique case (seg)
      SEG_INSTR: rd_sel = mem_rd[WIDTH-1:0];
      SEG_D16:   rd_sel = mem_rd[2*WIDTH-1:WIDTH];
      SEG_D8:    rd_sel = mem_rd[3*WIDTH-1:2*WIDTH];
      default:   rd_sel = '0;
    endcase
  end

  // Memory-side drive: derived from registered state so reset kills mem_we at once.
  always_comb begin
    mem_we             = 4'b0000;
    mem_a              = '0;
    mem_a[WIDTH-1:0]   = fetch_addr;
    mem_wd             = {3{wdata_q}};
    if (busy) begin
      mem_we = {1'b0, seg == SEG_D8, seg == SEG_D16, seg == SEG_INSTR} & {4{we_q & valid}};
      unique case (seg)
        SEG_INSTR: mem_a[WIDTH-1:0]         = WIDTH'(off);
        SEG_D16:   mem_a[2*WIDTH-1:WIDTH]   = WIDTH'(off);
        SEG_D8:    mem_a[3*WIDTH-1:2*WIDTH] = WIDTH'(off);
        default:   ;
      endcase
    end
  end

  assign fetch_stall = busy && (seg == SEG_INSTR) && valid;
  assign fetch_instr = mem_rd[WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      gnt     <= 2'b00;
      rvalid  <= 2'b00;
      err     <= 1'b0;
      rdata   <= '0;
    end else begin
      gnt    <= 2'b00;
      rvalid <= 2'b00;
      unique case (state_q)
        IDLE: begin
          if (|win) begin
            port_q  <= win[1];
            we_q    <= win[1] ? we[1] : we[0];
            addr_q  <= win[1] ? addr[2*WIDTH-1:WIDTH]  : addr[WIDTH-1:0];
            wdata_q <= win[1] ? wdata[2*WIDTH-1:WIDTH] : wdata[WIDTH-1:0];
            gnt     <= win;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          err <= ~valid;
          // Writes leave rdata alone; dropped accesses return zero.
          if (!valid)     rdata <= '0;
          else if (!we_q) rdata <= rd_sel;
          rvalid  <= port_q ? 2'b10 : 2'b01;
          state_q <= RESP;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter with a behavioural segmented memory.
module tb_mem_access_arbiter;

  localparam int unsigned W = 36;

  logic           clk = 1'b0;
  logic           reset;
  logic [1:0]     req, we;
  logic [2*W-1:0] addr, wdata;
  logic [1:0]     gnt, rvalid;
  logic [W-1:0]   rdata;
  logic           err;
  logic [W-1:0]   fetch_addr;
  logic [W-1:0]   fetch_instr;
  logic           fetch_stall;
  logic [3:0]     mem_we;
  logic [3*W-1:0] mem_a, mem_wd, mem_rd;

  int n_checks = 0;
  int n_err    = 0;

  mem_access_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .we          (we),
    .addr        (addr),
    .wdata       (wdata),
    .gnt         (gnt),
    .rvalid      (rvalid),
    .rdata       (rdata),
    .err         (err),
    .fetch_addr  (fetch_addr),
    .fetch_instr (fetch_instr),
    .fetch_stall (fetch_stall),
    .mem_we      (mem_we),
    .mem_a       (mem_a),
    .mem_wd      (mem_wd),
    .mem_rd      (mem_rd)
  );

  always #5 clk = ~clk;

  // Behavioural memory: seg0 36-bit, seg1 16-bit, seg2 8-bit, zero-extended reads.
  logic [W-1:0] seg0_m [1024];
  logic [15:0]  seg1_m [102];
  logic [7:0]   seg2_m [100];
  logic         mem_ready = 1'b0;
  logic [W-1:0] a0, a1, a2;

  always_comb begin
    a0 = mem_a[W-1:0];
    a1 = mem_a[2*W-1:W];
    a2 = mem_a[3*W-1:2*W];
    mem_rd = '0;
    if (a0 < 1024) mem_rd[W-1:0]     = seg0_m[a0[9:0]];
    if (a1 < 102)  mem_rd[W+15:W]    = seg1_m[a1[6:0]];
    if (a2 < 100)  mem_rd[2*W+7:2*W] = seg2_m[a2[6:0]];
  end

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 1024; i++) seg0_m[i] <= 36'h1_0000_0000 + W'(i);
      for (int i = 0; i < 102; i++)  seg1_m[i] <= 16'(i * 3);
      for (int i = 0; i < 100; i++)  seg2_m[i] <= 8'h00;
      mem_ready <= 1'b1;
    end else begin
      if (mem_we[0] && a0 < 1024) seg0_m[a0[9:0]] <= mem_wd[W-1:0];
      if (mem_we[1] && a1 < 102)  seg1_m[a1[6:0]] <= mem_wd[W+15:W];
      if (mem_we[2] && a2 < 100)  seg2_m[a2[6:0]] <= mem_wd[2*W+7:2*W];
    end
  end

  typedef struct {
    logic        port;
    logic        wr;
    logic [1:0]  seg;
    int unsigned off;
    logic [W-1:0] wd;
    logic [3:0]  exp_we;
    logic        exp_err;
    logic [W-1:0] exp_rdata;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_port(input logic p, input logic wr, input logic [1:0] sg,
                            input int unsigned off, input logic [W-1:0] wd);
    we[p]                  = wr;
    addr[int'(p)*W +: W]   = {sg, 34'(off)};
    wdata[int'(p)*W +: W]  = wd;
  endtask

  // One single-requester transaction with its gnt, mem_we, rvalid, err, rdata checks.
  task automatic access(input vec_t v);
    logic [1:0] oh;
    int n;
    oh = v.port ? 2'b10 : 2'b01;
    @(negedge clk);
    drive_port(v.port, v.wr, v.seg, v.off, v.wd);
    req = oh;
    n = 0;
    do begin tick(); n++; end while (gnt == 2'b00 && n < 6);
    chk("gnt", 64'(gnt), 64'(oh));
    chk("mem_we", 64'(mem_we), 64'(v.exp_we));
    req = 2'b00;
    tick();
    chk("rvalid", 64'(rvalid), 64'(oh));
    chk("err", 64'(err), 64'(v.exp_err));
    if (!v.wr || v.exp_err) chk("rdata", 64'(rdata), 64'(v.exp_rdata));
    tick();
    chk("rvalid_clear", 64'(rvalid), 64'd0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b1, 2'd1, 5,    36'h1234, 4'b0010, 1'b0, 36'h0};
    vecs[1] = '{1'b0, 1'b0, 2'd1, 5,    36'h0,    4'b0000, 1'b0, 36'h1234};
    vecs[2] = '{1'b1, 1'b1, 2'd2, 99,   36'h5A,   4'b0100, 1'b0, 36'h0};
    vecs[3] = '{1'b1, 1'b1, 2'd2, 100,  36'hFF,   4'b0000, 1'b1, 36'h0};
    vecs[4] = '{1'b1, 1'b0, 2'd2, 99,   36'h0,    4'b0000, 1'b0, 36'h5A};
    vecs[5] = '{1'b0, 1'b0, 2'd3, 0,    36'h0,    4'b0000, 1'b1, 36'h0};
    vecs[6] = '{1'b0, 1'b0, 2'd0, 1024, 36'h0,    4'b0000, 1'b1, 36'h0};
    vecs[7] = '{1'b1, 1'b0, 2'd1, 101,  36'h0,    4'b0000, 1'b0, 36'h12F};
    vecs[8] = '{1'b1, 1'b0, 2'd1, 102,  36'h0,    4'b0000, 1'b1, 36'h0};
    vecs[9] = '{1'b0, 1'b0, 2'd0, 1023, 36'h0,    4'b0000, 1'b0, 36'h1_0000_03FF};

    reset = 1'b1; req = 2'b00; we = 2'b00; addr = '0; wdata = '0; fetch_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_stall", 64'(fetch_stall), 64'd0);

    // Simultaneous requests from reset: port 0 first, then alternate.
    @(negedge clk);
    drive_port(1'b0, 1'b0, 2'd1, 0, '0);
    drive_port(1'b1, 1'b0, 2'd1, 1, '0);
    req = 2'b11;
    tick(); chk("rr_gnt_first", 64'(gnt), 64'h1);
    req = 2'b10;
    tick(); chk("rr_rvalid_p0", 64'(rvalid), 64'h1);
    chk("rr_rdata_p0", 64'(rdata), 64'h0);
    tick(); chk("rr_idle_gnt", 64'(gnt), 64'h0);
    tick(); chk("rr_gnt_second", 64'(gnt), 64'h2);
    req = 2'b00;
    tick(); chk("rr_rvalid_p1", 64'(rvalid), 64'h2);
    chk("rr_rdata_p1", 64'(rdata), 64'h3);
    tick();
    @(negedge clk);
    req = 2'b11;
    tick(); chk("rr_gnt_third", 64'(gnt), 64'h1);
    req = 2'b10;
    tick(); tick(); tick(); chk("rr_gnt_fourth", 64'(gnt), 64'h2);
    req = 2'b00;
    tick(); tick();

    for (int i = 0; i < 10; i++) access(vecs[i]);

    // Segment 0 write steals the fetch port for exactly one cycle.
    @(negedge clk);
    fetch_addr = 36'd10;
    #1;
    chk("fetch_pass_a", 64'(mem_a[W-1:0]), 64'd10);
    chk("fetch_pass_instr", 64'(fetch_instr), 64'h1_0000_000A);
    fetch_addr = 36'd3;
    drive_port(1'b1, 1'b1, 2'd0, 3, 36'h9_8765_4321);
    req = 2'b10;
    tick();
    chk("f_gnt", 64'(gnt), 64'h2);
    chk("f_stall", 64'(fetch_stall), 64'h1);
    chk("f_mem_a0", 64'(mem_a[W-1:0]), 64'd3);
    chk("f_mem_we", 64'(mem_we), 64'b0001);
    req = 2'b00;
    tick();
    chk("f_stall_clear", 64'(fetch_stall), 64'h0);
    chk("f_new_instr", 64'(fetch_instr), 64'h9_8765_4321);
    chk("f_rvalid", 64'(rvalid), 64'h2);
    tick();

    // Reset in the middle of a write must suppress it.
    @(negedge clk);
    drive_port(1'b0, 1'b1, 2'd1, 7, 36'hBEEF);
    req = 2'b01;
    tick();
    chk("rb_mem_we", 64'(mem_we), 64'b0010);
    #2 reset = 1'b1;
    #1 chk("rb_mem_we_async", 64'(mem_we), 64'd0);
    req = 2'b00;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rb_mem_kept", 64'(seg1_m[7]), 64'd21);
    chk("rb_gnt", 64'(gnt), 64'd0);
    chk("rb_rvalid", 64'(rvalid), 64'd0);
    chk("rb_err", 64'(err), 64'd0);
    chk("rb_rdata", 64'(rdata), 64'd0);
    chk("rb_stall", 64'(fetch_stall), 64'd0);
    access('{1'b0, 1'b0, 2'd1, 7, 36'h0, 4'b0000, 1'b0, 36'd21});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
